serdes_multilane: RTL and testbench

Parametrised multi-lane serial link: a transmitter that splits each parallel word across `LANES` serial lanes, and a receiver that reassembles, parity-checks and presents the word with backpressure. It is the successor to the single-lane loopback serdes. The serial lanes are exposed as ports, and `loopback_i` selects internal wrap-around, so the block can be looped back on-chip or connected to a far-end instance. It sits between a parallel producer (directly or behind a FIFO) and a parallel consumer.

---
 rtl/serdes_pkg.sv | 26 ++
 rtl/serdes_multilane_rx.sv | 135 +++++++++++++
 rtl/serdes_multilane.sv | 149 ++++++++++++++
 tb/tb_serdes_multilane.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and elaboration helpers for the multi-lane serial link.
package serdes_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PARITY} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_CHECK} rx_state_t;

    // Widest lane slice the parity helper accepts; narrower slices are zero-extended.
    localparam int MAX_SLICE_W = 64;

    function automatic int beats_of(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

    function automatic int cnt_w_of(input int beats);
        return $clog2(beats + 1);
    endfunction

    function automatic logic lanes_divide(input int data_width, input int lanes);
        return (lanes >= 1) && (lanes <= data_width) && ((data_width % lanes) == 0);
    endfunction

    function automatic logic slice_parity(input logic [MAX_SLICE_W-1:0] slice);
        return ^slice;
    endfunction

endpackage

// File: rtl/serdes_multilane_rx.sv
// Receive side: gathers lane beats into a word, checks per-lane parity and
// holds the result in a single output register with a valid/ready handshake.
module serdes_multilane_rx
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int HAS_PARITY = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [LANES-1:0]      serial_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic                  ready_in_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    output logic [LANES-1:0]      parity_err_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int BEATS = beats_of(DATA_WIDTH, LANES);
    localparam int CNT_W = cnt_w_of(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d, cur_beat;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [DATA_WIDTH-1:0] word_q, word_d, done_word;
    logic [LANES-1:0]      perr_q, perr_d, lane_perr, done_perr;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  data_beat, complete;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (BEATS == 1) begin : g_one
            assign shift_in[k] = serial_i[k];
        end else begin : g_many
            assign shift_in[k*BEATS +: BEATS] = {shift_q[k*BEATS +: BEATS-1], serial_i[k]};
        end
        assign lane_perr[k] = slice_parity(MAX_SLICE_W'(shift_q[k*BEATS +: BEATS])) ^ serial_i[k];
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        shift_d     = shift_q;
        word_d      = word_q;
        perr_d      = perr_q;
        valid_d     = valid_q && !ready_in_i;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        data_beat   = 1'b0;
        complete    = 1'b0;
        cur_beat    = beat_q;
        done_word   = shift_in;
        done_perr   = '0;

        if (enable_i) begin
            if (start_i) begin
                // A start always opens a fresh frame; whatever was in flight is lost.
                frame_err_d = (state_q != RX_IDLE);
                data_beat   = 1'b1;
                cur_beat    = '0;
            end else if (state_q == RX_COLLECT) begin
                data_beat = 1'b1;
            end else if (state_q == RX_CHECK) begin
                complete  = 1'b1;
                done_word = shift_q;
                done_perr = lane_perr;
            end

            if (data_beat) begin
                shift_d = shift_in;
                if (cur_beat == LAST_BEAT) begin
                    if (HAS_PARITY != 0) begin
                        state_d = RX_CHECK;
                        beat_d  = '0;
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    state_d = RX_COLLECT;
                    beat_d  = cur_beat + CNT_W'(1);
                end
            end
        end

        // The output slot is free if empty or being drained this very cycle.
        if (complete) begin
            state_d = RX_IDLE;
            beat_d  = '0;
            if (!valid_q || ready_in_i) begin
                word_d  = done_word;
                perr_d  = done_perr;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RX_IDLE;
            beat_q      <= '0;
            word_q      <= '0;
            perr_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            word_q      <= word_d;
            perr_q      <= perr_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    assign parallel_out_o = word_q;
    assign valid_out_o    = valid_q;
    assign parity_err_o   = perr_q;
    assign overrun_o      = overrun_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: rtl/serdes_multilane.sv
// Multi-lane serial link: TX splits each word across LANES lanes MSB first,
// optionally followed by a parity beat; RX reassembles it, with optional loopback.
module serdes_multilane
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int HAS_PARITY = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] parallel_in_i,
    input  logic                  valid_in_i,
    output logic                  ready_o,
    output logic [LANES-1:0]      serial_out_o,
    output logic                  enable_o,
    output logic                  start_o,
    input  logic [LANES-1:0]      serial_in_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic                  loopback_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    input  logic                  ready_in_i,
    output logic [LANES-1:0]      parity_err_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int BEATS = beats_of(DATA_WIDTH, LANES);
    localparam int CNT_W = cnt_w_of(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!lanes_divide(DATA_WIDTH, LANES)) begin : g_bad_lanes
        $error("serdes_multilane: DATA_WIDTH must be a multiple of LANES");
    end

    tx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [DATA_WIDTH-1:0] word_q, word_d, word_shift;
    logic [LANES-1:0]      par_q, par_d, in_par, in_msb, next_msb;
    logic [LANES-1:0]      serial_q, serial_d;
    logic                  enable_q, enable_d;
    logic                  start_q, start_d;
    logic [LANES-1:0]      rx_serial;
    logic                  rx_enable, rx_start;

    // Each lane slice is shifted left in place so its MSB is always the next bit out.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign in_msb[k] = parallel_in_i[k*BEATS + BEATS - 1];
        assign in_par[k] = slice_parity(MAX_SLICE_W'(parallel_in_i[k*BEATS +: BEATS]));
        if (BEATS == 1) begin : g_one
            assign word_shift[k] = 1'b0;
        end else begin : g_many
            assign word_shift[k*BEATS +: BEATS] = {word_q[k*BEATS +: BEATS-1], 1'b0};
        end
        assign next_msb[k] = word_shift[k*BEATS + BEATS - 1];
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        word_d   = word_q;
        par_d    = par_q;
        serial_d = '0;
        enable_d = 1'b0;
        start_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (valid_in_i) begin
                    state_d  = TX_SHIFT;
                    beat_d   = '0;
                    word_d   = parallel_in_i;
                    par_d    = in_par;
                    serial_d = in_msb;
                    enable_d = 1'b1;
                    start_d  = 1'b1;
                end
            end
            TX_SHIFT: begin
                enable_d = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    if (HAS_PARITY != 0) begin
                        state_d  = TX_PARITY;
                        serial_d = par_q;
                    end else begin
                        state_d  = TX_IDLE;
                        enable_d = 1'b0;
                    end
                end else begin
                    beat_d   = beat_q + CNT_W'(1);
                    word_d   = word_shift;
                    serial_d = next_msb;
                end
            end
            TX_PARITY: state_d = TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= TX_IDLE;
            beat_q   <= '0;
            serial_q <= '0;
            enable_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            serial_q <= serial_d;
            enable_q <= enable_d;
            start_q  <= start_d;
        end
    end

    always_ff @(posedge clk_i) begin
        word_q <= word_d;
        par_q  <= par_d;
    end

    assign ready_o      = (state_q == TX_IDLE);
    assign serial_out_o = serial_q;
    assign enable_o     = enable_q;
    assign start_o      = start_q;

    assign rx_serial = loopback_i ? serial_q : serial_in_i;
    assign rx_enable = loopback_i ? enable_q : enable_i;
    assign rx_start  = loopback_i ? start_q  : start_i;

    serdes_multilane_rx #(
        .DATA_WIDTH(DATA_WIDTH),
        .LANES     (LANES),
        .HAS_PARITY(HAS_PARITY)
    ) u_rx (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .serial_i      (rx_serial),
        .enable_i      (rx_enable),
        .start_i       (rx_start),
        .ready_in_i    (ready_in_i),
        .parallel_out_o(parallel_out_o),
        .valid_out_o   (valid_out_o),
        .parity_err_o  (parity_err_o),
        .overrun_o     (overrun_o),
        .frame_err_o   (frame_err_o)
    );

endmodule

// File: tb/tb_serdes_multilane.sv
// Bench for serdes_multilane: three instances (2-lane, 2-lane+parity, 1-lane)
// checked against a word-level reference of lane slicing and even parity.
module tb_serdes_multilane;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pin  [NDUT];
    logic       vin  [NDUT];
    logic       rdy  [NDUT];
    logic [1:0] sout [NDUT];
    logic       en   [NDUT];
    logic       st   [NDUT];
    logic [1:0] sin  [NDUT];
    logic       eni  [NDUT];
    logic       sti  [NDUT];
    logic       lb   [NDUT];
    logic [7:0] pout [NDUT];
    logic       vout [NDUT];
    logic       rin  [NDUT];
    logic [1:0] perr [NDUT];
    logic       ovr  [NDUT];
    logic       ferr [NDUT];

    int nvec;
    int nerr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 2) ? 1 : 2;
        localparam int P = (g == 1) ? 1 : 0;
        logic [L-1:0] so, si, pe;
        assign si      = sin[g][L-1:0];
        assign sout[g] = 2'(so);
        assign perr[g] = 2'(pe);
        serdes_multilane #(.DATA_WIDTH(8), .LANES(L), .HAS_PARITY(P)) u_dut (
            .clk_i(clk), .rst_n_i(rst_n),
            .parallel_in_i(pin[g]), .valid_in_i(vin[g]), .ready_o(rdy[g]),
            .serial_out_o(so), .enable_o(en[g]), .start_o(st[g]),
            .serial_in_i(si), .enable_i(eni[g]), .start_i(sti[g]),
            .loopback_i(lb[g]),
            .parallel_out_o(pout[g]), .valid_out_o(vout[g]), .ready_in_i(rin[g]),
            .parity_err_o(pe), .overrun_o(ovr[g]), .frame_err_o(ferr[g])
        );
    end

    function automatic int lanes_of(input int d);
        return (d == 2) ? 1 : 2;
    endfunction

    function automatic int par_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int beats_total(input int d);
        return 8 / lanes_of(d) + par_of(d);
    endfunction

    // Reference: lane k carries bits [k*B +: B] MSB first; beat B is even parity of that slice.
    function automatic logic [1:0] model_beat(input int d, input logic [7:0] w, input int i);
        int         lanes;
        int         beats;
        int         slice;
        logic [1:0] r;
        lanes = lanes_of(d);
        beats = 8 / lanes;
        r     = 2'b00;
        for (int k = 0; k < lanes; k++) begin
            slice = (int'(w) >> (k * beats)) & ((1 << beats) - 1);
            if (i < beats) r[k] = ((slice >> (beats - 1 - i)) & 1) != 0;
            else           r[k] = ($countones(slice) % 2) == 1;
        end
        return r;
    endfunction

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            nvec++;
            if (rdy[d] !== 1'b1) begin
                nerr++;
                $display("FAIL reset_ready dut%0d: got %b want 1", d, rdy[d]);
            end
            nvec++;
            if ({en[d], st[d], sout[d]} !== 4'b0000) begin
                nerr++;
                $display("FAIL reset_tx dut%0d: en/st/lanes got %b%b_%b want 00_00", d, en[d], st[d], sout[d]);
            end
            nvec++;
            if ({vout[d], pout[d], perr[d], ovr[d], ferr[d]} !== 13'h0) begin
                nerr++;
                $display("FAIL reset_rx dut%0d: valid/word/perr/ovr/ferr got %b/%h/%b/%b/%b want all 0",
                         d, vout[d], pout[d], perr[d], ovr[d], ferr[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_lanes [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        pin[0] = 8'hA5;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        pin[0] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({en[0], st[0], sout[0], vout[0]} !== {1'b1, (i == 0), exp_lanes[i], 1'b0}) begin
                nerr++;
                $display("FAIL basic_beat%0d: en/st/lanes/valid got %b%b_%b_%b want 1%b_%b_0",
                         i, en[0], st[0], sout[0], vout[0], (i == 0), exp_lanes[i]);
            end
            @(negedge clk);
        end
        nvec++;
        if ({rdy[0], vout[0], pout[0]} !== {1'b1, 1'b1, 8'hA5}) begin
            nerr++;
            $display("FAIL basic_word: ready/valid/word got %b/%b/%h want 1/1/a5", rdy[0], vout[0], pout[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_parity();
        logic [1:0] exp_lanes [5] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        pin[1] = 8'hB4;
        vin[1] = 1'b1;
        @(negedge clk);
        vin[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if ({en[1], st[1], sout[1]} !== {1'b1, (i == 0), exp_lanes[i]}) begin
                nerr++;
                $display("FAIL parity_beat%0d: en/st/lanes got %b%b_%b want 1%b_%b",
                         i, en[1], st[1], sout[1], (i == 0), exp_lanes[i]);
            end
            @(negedge clk);
        end
        nvec++;
        if ({vout[1], pout[1], perr[1]} !== {1'b1, 8'hB4, 2'b00}) begin
            nerr++;
            $display("FAIL parity_loop_word: valid/word/perr got %b/%h/%b want 1/b4/00", vout[1], pout[1], perr[1]);
        end
        @(negedge clk);
        lb[1] = 1'b0;
        exp_lanes[4] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            sin[1] = exp_lanes[i];
            eni[1] = 1'b1;
            sti[1] = (i == 0);
            @(negedge clk);
        end
        eni[1] = 1'b0;
        sti[1] = 1'b0;
        nvec++;
        if ({vout[1], pout[1], perr[1]} !== {1'b1, 8'hB4, 2'b10}) begin
            nerr++;
            $display("FAIL parity_inject: valid/word/perr got %b/%h/%b want 1/b4/10", vout[1], pout[1], perr[1]);
        end
        @(negedge clk);
        lb[1] = 1'b1;
    endtask

    task automatic test_random_loopback();
        logic [7:0] w;
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 6; n++) begin
                w = 8'($urandom);
                nvec++;
                if (rdy[d] !== 1'b1) begin
                    nerr++;
                    $display("FAIL rand_ready dut%0d word%0d: got %b want 1", d, n, rdy[d]);
                end
                pin[d] = w;
                vin[d] = 1'b1;
                @(negedge clk);
                vin[d] = 1'b0;
                pin[d] = 8'($urandom);
                for (int i = 0; i < beats_total(d); i++) begin
                    nvec++;
                    if ({en[d], st[d], sout[d], vout[d]} !== {1'b1, (i == 0), model_beat(d, w, i), 1'b0}) begin
                        nerr++;
                        $display("FAIL rand_beat dut%0d w=%h beat%0d: en/st/lanes/valid got %b%b_%b_%b want 1%b_%b_0",
                                 d, w, i, en[d], st[d], sout[d], vout[d], (i == 0), model_beat(d, w, i));
                    end
                    @(negedge clk);
                end
                nvec++;
                if ({vout[d], pout[d], perr[d]} !== {1'b1, w, 2'b00}) begin
                    nerr++;
                    $display("FAIL rand_word dut%0d: valid/word/perr got %b/%h/%b want 1/%h/00",
                             d, vout[d], pout[d], perr[d], w);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        int         idx = 0;
        int         ovr_cnt = 0;
        int         early = 0;
        rin[0] = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ovr_cnt += int'(ovr[0]);
            if (idx < 3 && rdy[0]) begin
                pin[0] = words[idx];
                vin[0] = 1'b1;
                idx++;
            end else begin
                vin[0] = 1'b0;
            end
            @(negedge clk);
        end
        nvec++;
        if (idx != 3 || ovr_cnt != 2) begin
            nerr++;
            $display("FAIL b2b_overrun: accepted %0d overrun pulses %0d want 3 and 2", idx, ovr_cnt);
        end
        nvec++;
        if ({vout[0], pout[0]} !== {1'b1, 8'h11}) begin
            nerr++;
            $display("FAIL b2b_held: valid/word got %b/%h want 1/11", vout[0], pout[0]);
        end
        rin[0] = 1'b1;
        @(negedge clk);
        rin[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            early += int'(vout[0]);
            @(negedge clk);
        end
        nvec++;
        if (early != 0) begin
            nerr++;
            $display("FAIL b2b_drained: valid seen %0d cycles after accept want 0", early);
        end
        pin[0] = 8'h44;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (4) @(negedge clk);
        nvec++;
        if ({vout[0], pout[0]} !== {1'b1, 8'h44}) begin
            nerr++;
            $display("FAIL b2b_next: valid/word got %b/%h want 1/44", vout[0], pout[0]);
        end
        rin[0] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame_abort();
        logic [7:0] w;
        int         ferr_cnt = 0;
        int         early = 0;
        w = 8'($urandom);
        lb[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ferr_cnt += int'(ferr[2]);
            early    += int'(vout[2]);
            eni[2] = 1'b1;
            sti[2] = (i == 0) || (i == 2);
            sin[2] = (i < 2) ? 2'($urandom_range(1)) : 2'((int'(w) >> (9 - i)) & 1);
            @(negedge clk);
        end
        eni[2] = 1'b0;
        sti[2] = 1'b0;
        ferr_cnt += int'(ferr[2]);
        nvec++;
        if (ferr_cnt != 1 || early != 0) begin
            nerr++;
            $display("FAIL abort_pulse: frame_err pulses %0d early valid %0d want 1 and 0", ferr_cnt, early);
        end
        nvec++;
        if ({vout[2], pout[2]} !== {1'b1, w}) begin
            nerr++;
            $display("FAIL abort_word: valid/word got %b/%h want 1/%h", vout[2], pout[2], w);
        end
        @(negedge clk);
        lb[2] = 1'b1;
    endtask

    task automatic test_stall();
        logic [7:0] w;
        int         early = 0;
        w = 8'($urandom);
        lb[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sin[1] = model_beat(1, w, i);
            eni[1] = 1'b1;
            sti[1] = (i == 0);
            @(negedge clk);
            if (i < 4) begin
                for (int s = 0; s < 3; s++) begin
                    early += int'(vout[1]);
                    eni[1] = 1'b0;
                    sti[1] = 1'($urandom_range(1));
                    sin[1] = 2'($urandom_range(3));
                    @(negedge clk);
                end
            end
        end
        eni[1] = 1'b0;
        sti[1] = 1'b0;
        nvec++;
        if (early != 0) begin
            nerr++;
            $display("FAIL stall_early: valid seen %0d cycles before last beat want 0", early);
        end
        nvec++;
        if ({vout[1], pout[1], perr[1]} !== {1'b1, w, 2'b00}) begin
            nerr++;
            $display("FAIL stall_word: valid/word/perr got %b/%h/%b want 1/%h/00", vout[1], pout[1], perr[1], w);
        end
        @(negedge clk);
        lb[1] = 1'b1;
    endtask

    task automatic test_reset_mid();
        int early = 0;
        pin[0] = 8'hC3;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({rdy[0], en[0], st[0], sout[0]} !== 5'b10000) begin
            nerr++;
            $display("FAIL rstmid_tx: ready/en/st/lanes got %b%b%b_%b want 100_00", rdy[0], en[0], st[0], sout[0]);
        end
        nvec++;
        if ({vout[0], pout[0], perr[0], ovr[0], ferr[0]} !== 13'h0) begin
            nerr++;
            $display("FAIL rstmid_rx: valid/word/perr got %b/%h/%b want 0/00/00", vout[0], pout[0], perr[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pin[0] = 8'h5A;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            early += int'(vout[0]);
            nvec++;
            if (sout[0] !== model_beat(0, 8'h5A, i)) begin
                nerr++;
                $display("FAIL rstmid_beat%0d: lanes got %b want %b", i, sout[0], model_beat(0, 8'h5A, i));
            end
            @(negedge clk);
        end
        nvec++;
        if (early != 0 || {vout[0], pout[0]} !== {1'b1, 8'h5A}) begin
            nerr++;
            $display("FAIL rstmid_word: early valid %0d valid/word got %b/%h want 0 and 1/5a", early, vout[0], pout[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            pin[d] = '0;
            vin[d] = 1'b0;
            sin[d] = '0;
            eni[d] = 1'b0;
            sti[d] = 1'b0;
            lb[d]  = 1'b1;
            rin[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_parity();
        test_random_loopback();
        test_back_to_back();
        test_frame_abort();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
